// File: rtl/regfile_pkg.sv
// Shared constants and port payload types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = $clog2(NREG_DEF);
  localparam int unsigned REG0     = 0;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
  } rd_port_t;

  typedef struct packed {
    logic                valid;
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker: one busy bit per register, set by alloc, cleared by writes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREG   = NREG_DEF,
  parameter  int unsigned NREAD  = 2,
  parameter  int unsigned NWRITE = 1,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc,
  input  logic [AW-1:0]                alloc_addr,
  input  logic [NWRITE-1:0]            wr_valid,
  input  logic [NWRITE-1:0][AW-1:0]    wr_addr,
  input  logic [NREAD-1:0][AW-1:0]     rd_addr,
  output logic [NREAD-1:0]             rd_busy_c
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clears first so a same-cycle alloc to the same register wins.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned w = 0; w < NWRITE; w++) begin
      if (wr_valid[w]) busy_d[wr_addr[w]] = 1'b0;
    end
    if (alloc && (alloc_addr != AW'(REG0))) busy_d[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    rd_busy_c = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      rd_busy_c[p] = busy_q[rd_addr[p]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads and per-register busy tracking.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREG   = NREG_DEF,
  parameter  int unsigned NREAD  = 2,
  parameter  int unsigned NWRITE = 1,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_rs_ren,
  input  logic [NREAD-1:0][AW-1:0]      i_rs_raddr,
  output logic [NREAD-1:0][XLEN-1:0]    o_rs_rdata,
  output logic [NREAD-1:0]              o_rs_busy,
  input  logic [NWRITE-1:0]             i_rd_wvalid,
  input  logic [NWRITE-1:0][AW-1:0]     i_rd_waddr,
  input  logic [NWRITE-1:0][XLEN-1:0]   i_rd_wdata,
  input  logic                          i_rd_alloc,
  input  logic [AW-1:0]                 i_rd_alloc_addr
);

  logic [XLEN-1:0]            regs [NREG];
  logic [NREAD-1:0]           sb_busy_c;
  logic [NREAD-1:0][XLEN-1:0] rd_data_c;
  logic [NREAD-1:0]           rd_busy_c;

  regfile_scoreboard #(
    .NREG   (NREG),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .alloc      (i_rd_alloc),
    .alloc_addr (i_rd_alloc_addr),
    .wr_valid   (i_rd_wvalid),
    .wr_addr    (i_rd_waddr),
    .rd_addr    (i_rs_raddr),
    .rd_busy_c  (sb_busy_c)
  );

  // Later ports overwrite earlier ones, so the highest-indexed write wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWRITE; w++) begin
        if (i_rd_wvalid[w] && (i_rd_waddr[w] != AW'(REG0))) begin
          regs[i_rd_waddr[w]] <= i_rd_wdata[w];
        end
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      rd_data_c[p] = (i_rs_raddr[p] == AW'(REG0)) ? '0 : regs[i_rs_raddr[p]];
      rd_busy_c[p] = sb_busy_c[p];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned w = 0; w < NWRITE; w++) begin
        if (i_rd_wvalid[w] && (i_rd_waddr[w] == i_rs_raddr[p]) &&
            (i_rs_raddr[p] != AW'(REG0))) begin
          rd_data_c[p] = i_rd_wdata[w];
          rd_busy_c[p] = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rs_rdata <= '0;
      o_rs_busy  <= '0;
    end else if (i_rs_ren) begin
      o_rs_rdata <= rd_data_c;
      o_rs_busy  <= rd_busy_c;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned NREAD  = 2;
  localparam int unsigned NWRITE = 2;
  localparam int unsigned AW     = 5;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        ren;
  logic [NREAD-1:0][AW-1:0]    raddr;
  logic [NREAD-1:0][XLEN-1:0]  rdata;
  logic [NREAD-1:0]            busy;
  logic [NWRITE-1:0]           wvalid;
  logic [NWRITE-1:0][AW-1:0]   waddr;
  logic [NWRITE-1:0][XLEN-1:0] wdata;
  logic                        alloc;
  logic [AW-1:0]               alloc_addr;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [XLEN-1:0] m_reg    [NREG];
  bit              m_busy   [NREG];
  logic [XLEN-1:0] exp_data [NREAD];
  bit              exp_busy [NREAD];

  regfile_mp #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_rs_ren        (ren),
    .i_rs_raddr      (raddr),
    .o_rs_rdata      (rdata),
    .o_rs_busy       (busy),
    .i_rd_wvalid     (wvalid),
    .i_rd_waddr      (waddr),
    .i_rd_wdata      (wdata),
    .i_rd_alloc      (alloc),
    .i_rd_alloc_addr (alloc_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cycle, got, want);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < int'(NREG); r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
    for (int p = 0; p < int'(NREAD); p++) begin
      exp_data[p] = '0;
      exp_busy[p] = 1'b0;
    end
  endtask

  // Reference behaviour at a rising edge: reads see pre-edge state, then state updates.
  task automatic model_edge();
    logic [XLEN-1:0] d;
    bit b;
    int a;
    if (rst) return;
    if (ren) begin
      for (int p = 0; p < int'(NREAD); p++) begin
        a = int'(raddr[p]);
        d = (a == 0) ? '0 : m_reg[a];
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < int'(NWRITE); w++) begin
          if (wvalid[w] && int'(waddr[w]) == a && a != 0) begin
            d = wdata[w];
            b = 1'b0;
          end
        end
`endif
        exp_data[p] = d;
        exp_busy[p] = b;
      end
    end
    for (int w = 0; w < int'(NWRITE); w++) begin
      if (wvalid[w] && waddr[w] != '0) begin
        m_reg[waddr[w]]  = wdata[w];
        m_busy[waddr[w]] = 1'b0;
      end
    end
    if (alloc && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
  endtask

  task automatic compare_all();
    for (int p = 0; p < int'(NREAD); p++) begin
      check($sformatf("model_rdata%0d", p), rdata[p], exp_data[p]);
      check($sformatf("model_busy%0d", p), XLEN'(busy[p]), XLEN'(exp_busy[p]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    compare_all();
  endtask

  task automatic idle();
    ren        = 1'b0;
    raddr      = '0;
    wvalid     = '0;
    waddr      = '0;
    wdata      = '0;
    alloc      = 1'b0;
    alloc_addr = '0;
  endtask

  initial begin
    wr_port_t wp;
    rd_port_t rp;
    idle();
    rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("reset_rdata0", rdata[0], 32'h0);
    check("reset_busy0", XLEN'(busy[0]), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Basic write then dual-port read
    wvalid[0] = 1'b1; waddr[0] = 5'd3; wdata[0] = 32'hDEADBEEF;
    tick();
    idle(); ren = 1'b1; raddr[0] = 5'd3; raddr[1] = 5'd0;
    tick();
    check("basic_rdata0", rdata[0], 32'hDEADBEEF);
    check("basic_rdata1", rdata[1], 32'h0);

    // Two write ports to the same register
    idle(); wvalid = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7; wdata[0] = 32'h11; wdata[1] = 32'h22;
    tick();
    idle(); ren = 1'b1; raddr[0] = 5'd7;
    tick();
    check("collision_rdata0", rdata[0], 32'h22);

    // Write+alloc same register, then write and read it in one cycle
    idle(); wvalid[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h33; alloc = 1'b1; alloc_addr = 5'd9;
    tick();
    idle(); wvalid[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h55; ren = 1'b1; raddr[0] = 5'd9;
    tick();
`ifdef REGFILE_BYPASS_EN
    check("bypass_rdata0", rdata[0], 32'h55);
    check("bypass_busy0", XLEN'(busy[0]), 32'h0);
`else
    check("nobypass_rdata0", rdata[0], 32'h33);
    check("nobypass_busy0", XLEN'(busy[0]), 32'h1);
`endif
    idle(); ren = 1'b1; raddr[0] = 5'd9;
    tick();
    check("after_write_rdata0", rdata[0], 32'h55);
    check("after_write_busy0", XLEN'(busy[0]), 32'h0);

    // Scoreboard on x4
    idle(); alloc = 1'b1; alloc_addr = 5'd4;
    tick();
    idle(); ren = 1'b1; raddr[0] = 5'd4;
    tick();
    check("sb_alloc_busy0", XLEN'(busy[0]), 32'h1);
    idle(); wvalid[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 32'hA; alloc = 1'b1; alloc_addr = 5'd4;
    tick();
    idle(); ren = 1'b1; raddr[0] = 5'd4;
    tick();
    check("sb_alloc_wins_busy0", XLEN'(busy[0]), 32'h1);
    check("sb_alloc_wins_rdata0", rdata[0], 32'hA);
    idle(); wvalid[1] = 1'b1; waddr[1] = 5'd4; wdata[1] = 32'hB;
    tick();
    idle(); ren = 1'b1; raddr[0] = 5'd4;
    tick();
    check("sb_clear_busy0", XLEN'(busy[0]), 32'h0);

    // Same-cycle alloc is invisible to the read
    idle(); alloc = 1'b1; alloc_addr = 5'd6; ren = 1'b1; raddr[1] = 5'd6;
    tick();
    check("sb_sameedge_busy1", XLEN'(busy[1]), 32'h0);

    // Register 0: writes and allocs ignored
    idle(); wvalid[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'hFFFF; alloc = 1'b1; alloc_addr = 5'd0;
    tick();
    idle(); ren = 1'b1; raddr[1] = 5'd0;
    tick();
    check("x0_rdata1", rdata[1], 32'h0);
    check("x0_busy1", XLEN'(busy[1]), 32'h0);

    // Hold while ren is low
    idle(); wvalid[0] = 1'b1; waddr[0] = 5'd2; wdata[0] = 32'h10;
    tick();
    idle(); ren = 1'b1; raddr[0] = 5'd2;
    tick();
    idle(); wvalid[0] = 1'b1; waddr[0] = 5'd2; wdata[0] = 32'h77; alloc = 1'b1; alloc_addr = 5'd2; raddr[0] = 5'd2;
    tick();
    idle(); raddr[0] = 5'd2;
    tick();
    check("hold_rdata0", rdata[0], 32'h10);
    check("hold_busy0", XLEN'(busy[0]), 32'h0);
    idle(); ren = 1'b1; raddr[0] = 5'd2;
    tick();
    check("hold_release_rdata0", rdata[0], 32'h77);
    check("hold_release_busy0", XLEN'(busy[0]), 32'h1);

    // Reset asserted mid-cycle while a write to x5 is pending
    idle(); alloc = 1'b1; alloc_addr = 5'd12;
    tick();
    idle(); ren = 1'b1; raddr[0] = 5'd3; raddr[1] = 5'd12;
    tick();
    check("pre_reset_rdata0", rdata[0], 32'hDEADBEEF);
    check("pre_reset_busy1", XLEN'(busy[1]), 32'h1);
    idle(); wvalid[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'h99; ren = 1'b1; raddr[0] = 5'd5;
    #3 rst = 1'b1;
    model_reset();
    #1;
    check("midreset_rdata0", rdata[0], 32'h0);
    check("midreset_busy1", XLEN'(busy[1]), 32'h0);
    tick();
    rst = 1'b0;
    idle(); ren = 1'b1; raddr[0] = 5'd5; raddr[1] = 5'd3;
    tick();
    check("post_reset_x5", rdata[0], 32'h0);
    check("post_reset_x3", rdata[1], 32'h0);

    // Randomized traffic, biased to a few registers to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      idle();
      ren = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < int'(NREAD); p++) begin
        rp.addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
        raddr[p] = rp.addr;
      end
      for (int w = 0; w < int'(NWRITE); w++) begin
        wp.valid  = ($urandom_range(0, 2) == 0);
        wp.addr   = AW'($urandom_range(0, 7));
        wp.data   = $urandom();
        wvalid[w] = wp.valid;
        waddr[w]  = wp.addr;
        wdata[w]  = wp.data;
      end
      alloc      = ($urandom_range(0, 3) == 0);
      alloc_addr = AW'($urandom_range(0, 7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREG, default 32: number of registers (power of two, >=2); AW = $clog2(NREG) is derived, not overridable.
REQ-003 SHALL have parameter NREAD, default 2: number of read ports (1..4).
REQ-004 SHALL have parameter NWRITE, default 1: number of write ports (1..2).
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_rs_ren, input, 1: read enable, common to all read ports.
REQ-008 SHALL have port i_rs_raddr, input, NREAD x AW: read addresses.
REQ-009 SHALL have port o_rs_rdata, output, NREAD x XLEN: registered read data.
REQ-010 SHALL have port o_rs_busy, output, NREAD: registered pending-write flag per read port.
REQ-011 SHALL have port i_rd_wvalid, input, NWRITE: write strobes.
REQ-012 SHALL have port i_rd_waddr, input, NWRITE x AW: write addresses.
REQ-013 SHALL have port i_rd_wdata, input, NWRITE x XLEN: write data.
REQ-014 SHALL have port i_rd_alloc, input, 1: mark a destination register pending.
REQ-015 SHALL have port i_rd_alloc_addr, input, AW: register to mark pending.

Function
REQ-016 SHALL, when i_rs_ren=1, update each o_rs_rdata[p] and o_rs_busy[p] from i_rs_raddr[p] at the next clk edge (1-cycle latency).
REQ-017 SHALL hold o_rs_rdata and o_rs_busy unchanged while i_rs_ren=0.
REQ-018 SHALL read register 0 as zero, ignore writes to it, and never report it busy.
REQ-019 SHALL write i_rd_wdata[w] to i_rd_waddr[w] on each edge with i_rd_wvalid[w]=1; all other registers hold.
REQ-020 SHALL, when several write ports target the same address in one cycle, store only the highest-indexed port's data.
REQ-021 SHALL keep one busy bit per register: i_rd_alloc sets bit i_rd_alloc_addr; any valid write clears the bit at its address.
REQ-022 SHALL, when alloc and a write hit the same address in one cycle, leave the bit set (alloc wins).
REQ-023 SHALL exclude a same-cycle alloc from o_rs_busy: a read sees the pre-edge busy bit, subject to REQ-026.
REQ-024 SHALL ignore i_rd_alloc with i_rd_alloc_addr=0.

Reset
REQ-025 SHALL, while rst=1 and independent of clk, clear all registers, all busy bits, o_rs_rdata and o_rs_busy to 0; operation resumes on the first edge after rst falls; writes, allocs or reads in flight at assertion are discarded.

Configuration
REQ-026 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data (highest-indexed matching port) to o_rs_rdata and report o_rs_busy=0 for that address (unless a busy bit is set and no write clears it).
REQ-027 SHALL, without REGFILE_BYPASS_EN, return pre-write data and the pre-edge busy bit when a read and a write hit one address in the same cycle.

Structure
REQ-028 SHALL take the XLEN default, the register-0 index constant and the read/write port struct typedefs from shared package regfile_pkg.
REQ-029 SHALL place busy-bit tracking in one sub-module, regfile_scoreboard (set/clear/query, own async reset).

Verification
REQ-030 Reset: assert rst mid-write to x5 -> o_rs_rdata=0 and o_rs_busy=0 immediately; after release, a read of x5 returns 0.
REQ-031 Basic: write x3=0xDEADBEEF; next cycle read port0=x3, port1=x0 with ren -> one cycle later rdata0=0xDEADBEEF, rdata1=0.
REQ-032 Collision (NWRITE=2): port0 x7=0x11, port1 x7=0x22 in the same cycle -> a later read of x7 returns 0x22.
REQ-033 Bypass: write x9=0x55 and read x9 in the same cycle -> with REGFILE_BYPASS_EN rdata=0x55 and busy=0; without it, rdata = old value.
REQ-034 Scoreboard: alloc x4; read x4 next cycle -> busy=1; write x4 with alloc x4 in the same cycle -> bit stays 1; a later write alone -> read shows busy=0.
REQ-035 Hold: ren=0 while x2 changes -> rdata and busy hold their prior values until ren=1.
